// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the set/reset latch pulse driver.
// Holds FSM state encodings, default timing and a width helper.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SET_P,
        RST_P,
        GAP
    } state_t;

    localparam int DEF_DEB_CYCLES   = 16;
    localparam int DEF_PULSE_CYCLES = 4;
    localparam int DEF_GAP_CYCLES   = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sr_pulse_driver_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce counter, press strobe.
// rise is combinational so the request lands with the level update.
module btn_debounce
    import sr_drv_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int CW = clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEB_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;

    assign rise = sync[1] && !level && (cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LIMIT) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_pulse_driver.sv
// One-shot active-low pulse sequencer feeding a NAND set/reset latch.
// Debounced presses queue as pending flags; FSM issues pulses with dead-time.
module sr_pulse_driver
    import sr_drv_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic conflict
);

    localparam int LONGEST = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW = clog2(LONGEST + 1);
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pend_s;
    logic          pend_r;
    logic          first_r;

    logic set_rise;
    logic reset_rise;
    logic set_new;
    logic rst_new;
    logic both;
    logic go;
    logic pick_r;
    logic take_s;
    logic take_r;
    logic kept_s;
    logic kept_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (set_btn),
        .rise (set_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (reset_btn),
        .rise (reset_rise)
    );

    assign both    = set_rise & reset_rise;
    assign set_new = set_rise & ~reset_rise;
    assign rst_new = reset_rise & ~set_rise;

    // Older request wins when both are waiting at a service point
    assign go     = (state == IDLE) || ((state == GAP) && (cnt == G_LAST));
    assign pick_r = pend_r & (~pend_s | first_r);
    assign take_r = go & pick_r;
    assign take_s = go & pend_s & ~pick_r;
    assign kept_s = pend_s & ~take_s;
    assign kept_r = pend_r & ~take_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            s_n      <= 1'b1;
            r_n      <= 1'b1;
            busy     <= 1'b0;
            conflict <= 1'b0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            first_r  <= 1'b0;
        end else begin
            conflict <= both;
            pend_s   <= kept_s | set_new;
            pend_r   <= kept_r | rst_new;
            if (set_new && !kept_r) begin
                first_r <= 1'b0;
            end else if (rst_new && !kept_s) begin
                first_r <= 1'b1;
            end

            unique case (state)
                IDLE, GAP: begin
                    if (state == GAP && cnt != G_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (take_s) begin
                        state <= SET_P;
                        s_n   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end else if (take_r) begin
                        state <= RST_P;
                        r_n   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SET_P: begin
                    if (cnt == P_LAST) begin
                        state <= GAP;
                        s_n   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RST_P: begin
                    if (cnt == P_LAST) begin
                        state <= GAP;
                        r_n   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
